gpio_rx: RTL and testbench
==========================

# gpio_rx

Serial receiver that consumes the single-wire `GPIO` frame stream produced by the message transmitter and recovers the 5-bit message. It sits directly downstream of the transmitter, either in a loopback build or on the receiving board. It synchronises the line, detects frames, samples each bit at mid-period and presents the decoded word with a one-cycle `valid` strobe. It also reports framing errors and a wrapping frame count.

## Interface
- `BIT_CYCLES`, 1000: clock cycles per bit in mode 0; must be even and ≥ 4.
- `MSG_W`, 5: message width in bits.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset; one clock; reset is synchronous and active-high.
- `mode` in 1: bit-rate select; 0 = `BIT_CYCLES` per bit, 1 = 2×`BIT_CYCLES` per bit.
- `GPIO` in 1: asynchronous serial line; idles high.
- `message` out `MSG_W`: last correctly received word.
- `valid` out 1: one-cycle strobe when `message` updates.
- `frame_err` out 1: one-cycle strobe on a bad stop bit.
- `busy` out 1: high while not in IDLE.
- `rx_count` out 3: good frames received, modulo 8.

## Operation
- Frame format, fixed: idle high; start bit low; `MSG_W` data bits, MSB first; one stop bit high.
- Input: two-flop synchroniser on `GPIO`, both flops reset to 1. All decisions use the synchronised value `s`.
- Bit period P is latched from `mode` when a start edge is detected. A change of `mode` mid-frame has no effect until the next frame.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: a high→low transition on `s` loads the bit timer with P/2 − 1 and moves to START.
- START: when the timer expires, sample. If the sample is low → DATA, with the timer at P − 1 and bit index 0. If high → false start, back to IDLE with no strobe.
- DATA: on each timer expiry, sample and shift into the receive shift register (MSB first) and reload P − 1. After bit `MSG_W`−1 → STOP.
- STOP: on expiry, sample.
  - High: copy the shift register to `message`, pulse `valid`, increment `rx_count` (7 wraps to 0), go to IDLE.
  - Low: pulse `frame_err`, leave `message` and `rx_count` unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until `s` = 1, then go to IDLE. This prevents a held-low line from retriggering.
- `valid` and `frame_err` are never high in the same cycle.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: `message` = 0, `valid` = 0, `frame_err` = 0, `busy` = 0, `rx_count` = 0, state IDLE, synchroniser = 1. Reset mid-frame aborts the frame with no strobe.
- Synchroniser latency: 2 cycles from a `GPIO` edge to `s`.
- Let t0 be the first cycle with `s` low. Sample points:
  - start bit at t0 + P/2;
  - data bit i at t0 + P/2 + (i+1)·P;
  - stop bit at t0 + P/2 + (`MSG_W`+1)·P.
- `valid`/`frame_err` are high for exactly the one cycle after the stop sample cycle. `message` and `rx_count` change in that same cycle.
- A new start edge is accepted in the first IDLE cycle, i.e. one cycle after the strobe. Back-to-back frames with a one-bit stop are received without loss.
- Timer width: enough bits for 2×`BIT_CYCLES` − 1.

## Configuration
- `GPIO_RX_MAJORITY_EN` defined: each sample is the 2-of-3 majority of `s` over the sample cycle and the two cycles before it. This rejects a single-cycle glitch. Sample points are unchanged.
- Not defined: each sample is the single value of `s` in the sample cycle.

## Test plan
- `BIT_CYCLES`=8, `mode`=0, send frame 10101 → `valid` for 1 cycle at t0+4+6·8+1, `message`=5'b10101, `rx_count`=1, `frame_err` never high.
- `mode`=1, send 01100 with P=16 → `message`=5'b01100; changing `mode` to 0 mid-frame still decodes correctly.
- Stop bit driven low on frame 11111 → `frame_err` pulse, `message` keeps its old value, `busy` stays high until the line returns high.
- 3-cycle low glitch on an idle line → false start, back to IDLE; no `valid`, no `frame_err`, `rx_count` unchanged.
- 9 consecutive good frames back-to-back → 9 `valid` pulses, `rx_count` wraps to 1. Assert `rst` mid-frame → all outputs at reset values next cycle, no strobe.
- With `GPIO_RX_MAJORITY_EN`: a 1-cycle inverted glitch at a data sample point → correct word. Without the macro, the same stimulus → corrupted bit.

Source files
------------

// File: rtl/gpio_rx_if.sv
// gpio_rx_if: connection bundle between a GPIO frame source and the gpio_rx
// receiver.
//   mode      - bit-rate select (0: BIT_CYCLES per bit, 1: 2x BIT_CYCLES)
//   GPIO      - asynchronous serial line, idles high
//   message   - last correctly received word
//   valid     - one-cycle strobe when message updates
//   frame_err - one-cycle strobe on a bad stop bit
//   busy      - receiver not idle
//   rx_count  - good frames received, modulo 8
// master: the side that drives the line (transmitter or bench).
// slave : the receiver.
interface gpio_rx_if #(
    parameter int MSG_W = 5
);
    logic             mode;
    logic             GPIO;
    logic [MSG_W-1:0] message;
    logic             valid;
    logic             frame_err;
    logic             busy;
    logic [2:0]       rx_count;

    modport master (
        output mode, GPIO,
        input  message, valid, frame_err, busy, rx_count
    );

    modport slave (
        input  mode, GPIO,
        output message, valid, frame_err, busy, rx_count
    );
endinterface

// File: rtl/gpio_rx.sv
// gpio_rx: single-wire serial frame receiver.
// Frame: idle high, start bit low, MSG_W data bits MSB first, stop bit high.
// The line is synchronised with two flops, a start edge is detected in IDLE,
// each bit is sampled at mid-period and a good word is presented on message
// with a one-cycle valid strobe. A low stop bit gives a one-cycle frame_err
// strobe and the receiver then waits for the line to return high.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   rx  - gpio_rx_if.slave (mode, GPIO in; message, valid, frame_err,
//         busy, rx_count out)
// Optional build macro: GPIO_RX_MAJORITY_EN - each bit sample is the 2-of-3
// majority of the synchronised line over the sample cycle and the two cycles
// before it, rejecting single-cycle glitches.
module gpio_rx #(
    parameter int BIT_CYCLES = 1000,
    parameter int MSG_W      = 5
) (
    input  logic     clk,
    input  logic     rst,
    gpio_rx_if.slave rx
);
    localparam int TW = $clog2(2 * BIT_CYCLES);
    localparam int IW = (MSG_W > 1) ? $clog2(MSG_W) : 1;

    // Timer reload values for half and full bit periods in both modes.
    localparam logic [TW-1:0] HALF_M0 = TW'(BIT_CYCLES / 2 - 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] FULL_M0 = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(2 * BIT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(MSG_W - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic             sync1_r;
    logic             s_r;
    logic             s_d1_r;
`ifdef GPIO_RX_MAJORITY_EN
    logic             s_d2_r;
`endif
    state_t           state_r;
    logic [TW-1:0]    timer_r;
    logic             mode_lat_r;
    logic [IW-1:0]    bit_idx_r;
    logic [MSG_W-1:0] shreg_r;
    logic [MSG_W-1:0] message_r;
    logic             valid_r;
    logic             frame_err_r;
    logic             busy_r;
    logic [2:0]       rx_count_r;

    logic             sample_s;
    logic [TW-1:0]    full_s;

    // Two-flop synchroniser plus history taps for edge detect and majority.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            s_r     <= 1'b1;
            s_d1_r  <= 1'b1;
`ifdef GPIO_RX_MAJORITY_EN
            s_d2_r  <= 1'b1;
`endif
        end else begin
            sync1_r <= rx.GPIO;
            s_r     <= sync1_r;
            s_d1_r  <= s_r;
`ifdef GPIO_RX_MAJORITY_EN
            s_d2_r  <= s_d1_r;
`endif
        end
    end

    // Bit sample value and full-period reload for the latched bit rate.
    always_comb begin
`ifdef GPIO_RX_MAJORITY_EN
        sample_s = maj3(s_r, s_d1_r, s_d2_r);
`else
        sample_s = s_r;
`endif
        full_s = mode_lat_r ? FULL_M1 : FULL_M0;
    end

    // Receive FSM with registered outputs; strobes default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            timer_r     <= {TW{1'b0}};
            mode_lat_r  <= 1'b0;
            bit_idx_r   <= {IW{1'b0}};
            shreg_r     <= {MSG_W{1'b0}};
            message_r   <= {MSG_W{1'b0}};
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
            rx_count_r  <= 3'd0;
        end else begin
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // High-to-low on the synchronised line marks a start edge.
                    if (s_d1_r && !s_r) begin
                        mode_lat_r <= rx.mode;
                        timer_r    <= rx.mode ? HALF_M1 : HALF_M0;
                        state_r    <= START;
                        busy_r     <= 1'b1;
                    end else begin
                        busy_r     <= 1'b0;
                    end
                end
                START: begin
                    if (timer_r == {TW{1'b0}}) begin
                        if (!sample_s) begin
                            state_r   <= DATA;
                            timer_r   <= full_s;
                            bit_idx_r <= {IW{1'b0}};
                        end else begin
                            // Line back high at mid start bit: false start.
                            state_r   <= IDLE;
                            busy_r    <= 1'b0;
                        end
                    end else begin
                        timer_r <= timer_r - TW'(1);
                    end
                end
                DATA: begin
                    if (timer_r == {TW{1'b0}}) begin
                        shreg_r <= (shreg_r << 1) | MSG_W'(sample_s);
                        timer_r <= full_s;
                        if (bit_idx_r == LAST_BIT) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + IW'(1);
                        end
                    end else begin
                        timer_r <= timer_r - TW'(1);
                    end
                end
                STOP: begin
                    if (timer_r == {TW{1'b0}}) begin
                        if (sample_s) begin
                            message_r  <= shreg_r;
                            valid_r    <= 1'b1;
                            rx_count_r <= rx_count_r + 3'd1;
                            state_r    <= IDLE;
                            busy_r     <= 1'b0;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= WAIT_IDLE;
                        end
                    end else begin
                        timer_r <= timer_r - TW'(1);
                    end
                end
                WAIT_IDLE: begin
                    // Hold here while the line is low so it cannot retrigger.
                    if (s_r) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= WAIT_IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.message   = message_r;
    assign rx.valid     = valid_r;
    assign rx.frame_err = frame_err_r;
    assign rx.busy      = busy_r;
    assign rx.rx_count  = rx_count_r;

endmodule

// File: tb/tb_gpio_rx.sv
// tb_gpio_rx: directed self-checking bench for gpio_rx with BIT_CYCLES = 8.
module tb_gpio_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_cmp = 0;
    int n_err = 0;

    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int last_valid_cyc = 0;
    logic [4:0] last_msg = 5'd0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;
    int frame_start = 0;
    logic [4:0] exp_glitch;

    gpio_rx_if #(.MSG_W(5)) bus ();

    gpio_rx #(.BIT_CYCLES(8), .MSG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Strobe monitor: counts pulses and checks width and exclusivity.
    always @(negedge clk) begin
        if (bus.valid) begin
            chk("valid_width", int'(prev_v), 0);
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
            last_msg       <= bus.message;
        end
        if (bus.frame_err) begin
            chk("ferr_width", int'(prev_e), 0);
            ferr_cnt <= ferr_cnt + 1;
        end
        if (bus.valid || bus.frame_err)
            chk("strobe_excl", int'(bus.valid & bus.frame_err), 0);
        prev_v <= bus.valid;
        prev_e <= bus.frame_err;
    end

    // Drive ncyc cycles of a frame; optional one-cycle inversion and mode drop.
    task automatic send(input logic [4:0] d, input int p, input logic stopv,
                        input int g_off, input int f_off, input int ncyc);
        logic lvl;
        int   b;
        frame_start = cyc;
        for (int c = 0; c < ncyc; c++) begin
            b = c / p;
            if (b == 0) lvl = 1'b0;
            else if (b <= 5) lvl = d[5 - b];
            else lvl = stopv;
            if (c == g_off) lvl = ~lvl;
            if (c == f_off) bus.mode = 1'b0;
            bus.GPIO = lvl;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst(input string tag);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_message"}, int'(bus.message), 0);
        chk({tag, "_valid"}, int'(bus.valid), 0);
        chk({tag, "_ferr"}, int'(bus.frame_err), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_count"}, int'(bus.rx_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.GPIO = 1'b1;
        bus.mode = 1'b0;
`ifdef GPIO_RX_MAJORITY_EN
        exp_glitch = 5'b10101;
`else
        exp_glitch = 5'b10001;
`endif
        @(posedge clk); #1;
        pulse_rst("reset");
        idle(4);

        // Frame 10101, P = 8: strobe at t0+4+6*8+1 with t0 = drive+2.
        send(5'b10101, 8, 1'b1, -1, -1, 56);
        idle(4);
        chk("a_valid_cnt", valid_cnt, 1);
        chk("a_time", last_valid_cyc - frame_start, 55);
        chk("a_message", int'(bus.message), 5'b10101);
        chk("a_count", int'(bus.rx_count), 1);
        chk("a_ferr_cnt", ferr_cnt, 0);

        // Frame 01100, P = 16; mode drops to 0 during data bit 2.
        bus.mode = 1'b1;
        send(5'b01100, 16, 1'b1, -1, 48, 112);
        idle(4);
        chk("b_valid_cnt", valid_cnt, 2);
        chk("b_time", last_valid_cyc - frame_start, 107);
        chk("b_message", int'(bus.message), 5'b01100);
        chk("b_count", int'(bus.rx_count), 2);

        // Frame 11111 with stop bit low, line held low afterwards.
        send(5'b11111, 8, 1'b0, -1, -1, 56);
        idle(5);
        @(negedge clk);
        chk("c_ferr_cnt", ferr_cnt, 1);
        chk("c_valid_cnt", valid_cnt, 2);
        chk("c_message", int'(bus.message), 5'b01100);
        chk("c_count", int'(bus.rx_count), 2);
        chk("c_busy_held", int'(bus.busy), 1);
        @(posedge clk); #1;
        bus.GPIO = 1'b1;
        idle(5);
        @(negedge clk);
        chk("c_busy_release", int'(bus.busy), 0);
        @(posedge clk); #1;

        // Three-cycle low glitch on an idle line: false start.
        bus.GPIO = 1'b0;
        idle(3);
        bus.GPIO = 1'b1;
        @(negedge clk);
        chk("g_busy_start", int'(bus.busy), 1);
        idle(20);
        chk("g_valid_cnt", valid_cnt, 2);
        chk("g_ferr_cnt", ferr_cnt, 1);
        chk("g_count", int'(bus.rx_count), 2);
        chk("g_busy_idle", int'(bus.busy), 0);

        // One-cycle inversion landing on the data bit 2 sample point.
        send(5'b10101, 8, 1'b1, 28, -1, 56);
        idle(4);
        chk("m_valid_cnt", valid_cnt, 3);
        chk("m_message", int'(bus.message), int'(exp_glitch));
        chk("m_count", int'(bus.rx_count), 3);

        // Nine back-to-back frames from reset: count wraps to 1.
        pulse_rst("rst2");
        idle(4);
        for (int k = 0; k < 9; k++) begin
            send(5'((k * 7 + 3) % 32), 8, 1'b1, -1, -1, 56);
            chk("bb_message", int'(last_msg), (k * 7 + 3) % 32);
        end
        idle(4);
        chk("bb_valid_cnt", valid_cnt, 12);
        chk("bb_count", int'(bus.rx_count), 1);
        chk("bb_ferr_cnt", ferr_cnt, 1);

        // Reset in the middle of a frame aborts it without a strobe.
        send(5'b11111, 8, 1'b1, -1, -1, 20);
        @(negedge clk);
        chk("r_busy_before", int'(bus.busy), 1);
        @(posedge clk); #1;
        pulse_rst("rst_mid");
        idle(80);
        chk("r_valid_cnt", valid_cnt, 12);
        chk("r_ferr_cnt", ferr_cnt, 1);
        chk("r_count", int'(bus.rx_count), 0);
        chk("r_message", int'(bus.message), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
